// File: rtl/mr1_mem_arbiter.sv
// Two-to-one arbiter merging MR1 fetch and load/store channels onto one memory port,
// with an in-order source-ID FIFO steering read responses. Define MR1_ARB_RR_EN for round-robin.
module mr1_mem_arbiter #(
  parameter int OUTSTANDING_MAX = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        instr_req_valid,
  output logic        instr_req_ready,
  input  logic [31:0] instr_req_addr,
  output logic        instr_rsp_valid,
  output logic [31:0] instr_rsp_data,
  input  logic        data_req_valid,
  output logic        data_req_ready,
  input  logic        data_req_wr,
  input  logic [31:0] data_req_addr,
  input  logic [1:0]  data_req_size,
  input  logic [31:0] data_req_data,
  output logic        data_rsp_valid,
  output logic [31:0] data_rsp_data,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_wr,
  output logic [31:0] mem_req_addr,
  output logic [1:0]  mem_req_size,
  output logic [31:0] mem_req_data,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  output logic        rsp_err
);

  localparam int PW = (OUTSTANDING_MAX > 1) ? $clog2(OUTSTANDING_MAX) : 1;
  localparam int CW = $clog2(OUTSTANDING_MAX) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(OUTSTANDING_MAX);
  localparam logic SRC_INSTR = 1'b0;
  localparam logic SRC_DATA  = 1'b1;

  logic [OUTSTANDING_MAX-1:0] fifo_q, fifo_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic lock_q, lock_d, lock_src_q, lock_src_d, rsp_err_q, rsp_err_d;
`ifdef MR1_ARB_RR_EN
  logic last_src_q, last_src_d;
`endif

  logic full, empty, instr_elig, data_elig, grant, xfer, push, pop, head;

  // Eligibility only looks at registered occupancy, so responses never reach a ready.
  always_comb begin
    full       = (count_q == FULL_CNT);
    empty      = (count_q == '0);
    instr_elig = instr_req_valid && !full;
    data_elig  = data_req_valid && (data_req_wr || !full);
  end

  always_comb begin
    grant = SRC_DATA;
    if (lock_q)
      grant = lock_src_q;
`ifdef MR1_ARB_RR_EN
    else if (instr_elig && data_elig)
      grant = ~last_src_q;
`endif
    else if (data_elig)
      grant = SRC_DATA;
    else if (instr_elig)
      grant = SRC_INSTR;
  end

  always_comb begin
    mem_req_valid   = (grant == SRC_DATA) ? data_elig : instr_elig;
    mem_req_wr      = (grant == SRC_DATA) ? data_req_wr : 1'b0;
    mem_req_addr    = (grant == SRC_DATA) ? data_req_addr : instr_req_addr;
    mem_req_size    = (grant == SRC_DATA) ? data_req_size : 2'd2;
    mem_req_data    = (grant == SRC_DATA) ? data_req_data : 32'd0;
    instr_req_ready = (grant == SRC_INSTR) && mem_req_ready && instr_elig;
    data_req_ready  = (grant == SRC_DATA) && mem_req_ready && data_elig;
    xfer            = mem_req_valid && mem_req_ready;
    push            = xfer && ((grant == SRC_INSTR) || !data_req_wr);
  end

  always_comb begin
    pop             = mem_rsp_valid && !empty;
    head            = fifo_q[rd_ptr_q];
    instr_rsp_valid = pop && (head == SRC_INSTR);
    data_rsp_valid  = pop && (head == SRC_DATA);
    instr_rsp_data  = mem_rsp_data;
    data_rsp_data   = mem_rsp_data;
    rsp_err         = rsp_err_q;
  end

  always_comb begin
    fifo_d = fifo_q;
    if (push)
      fifo_d[wr_ptr_q] = grant;
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q;
    if (push && !pop)
      count_d = count_q + CW'(1);
    else if (pop && !push)
      count_d = count_q - CW'(1);
    // A stalled request pins the grant until it completes.
    lock_d     = mem_req_valid && !mem_req_ready;
    lock_src_d = grant;
    rsp_err_d  = rsp_err_q || (mem_rsp_valid && empty);
`ifdef MR1_ARB_RR_EN
    last_src_d = xfer ? grant : last_src_q;
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      lock_q     <= 1'b0;
      lock_src_q <= SRC_DATA;
      rsp_err_q  <= 1'b0;
`ifdef MR1_ARB_RR_EN
      last_src_q <= SRC_DATA;
`endif
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      lock_q     <= lock_d;
      lock_src_q <= lock_src_d;
      rsp_err_q  <= rsp_err_d;
`ifdef MR1_ARB_RR_EN
      last_src_q <= last_src_d;
`endif
    end
  end

  always_ff @(posedge clock) begin
    fifo_q <= fifo_d;
  end

endmodule

// File: tb/tb_mr1_mem_arbiter.sv
// Self-checking bench for mr1_mem_arbiter: directed scenarios plus randomized traffic
// against a queue-based reference model. Follows MR1_ARB_RR_EN like the design.
module tb_mr1_mem_arbiter;
  localparam int OM = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        instr_req_valid, instr_req_ready, instr_rsp_valid;
  logic [31:0] instr_req_addr, instr_rsp_data;
  logic        data_req_valid, data_req_ready, data_req_wr, data_rsp_valid;
  logic [31:0] data_req_addr, data_req_data, data_rsp_data;
  logic [1:0]  data_req_size;
  logic        mem_req_valid, mem_req_ready, mem_req_wr, mem_rsp_valid, rsp_err;
  logic [31:0] mem_req_addr, mem_req_data, mem_rsp_data;
  logic [1:0]  mem_req_size;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  mr1_mem_arbiter #(.OUTSTANDING_MAX(OM)) dut (
    .clock(clock), .reset(reset),
    .instr_req_valid(instr_req_valid), .instr_req_ready(instr_req_ready),
    .instr_req_addr(instr_req_addr), .instr_rsp_valid(instr_rsp_valid),
    .instr_rsp_data(instr_rsp_data),
    .data_req_valid(data_req_valid), .data_req_ready(data_req_ready),
    .data_req_wr(data_req_wr), .data_req_addr(data_req_addr),
    .data_req_size(data_req_size), .data_req_data(data_req_data),
    .data_rsp_valid(data_rsp_valid), .data_rsp_data(data_rsp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_wr(mem_req_wr), .mem_req_addr(mem_req_addr),
    .mem_req_size(mem_req_size), .mem_req_data(mem_req_data),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .rsp_err(rsp_err)
  );

  task automatic idle_inputs();
    instr_req_valid = 0; instr_req_addr = 0;
    data_req_valid = 0; data_req_wr = 0; data_req_addr = 0;
    data_req_size = 0; data_req_data = 0;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_data = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    @(posedge clock); @(posedge clock); #1;
    reset = 0;
  endtask

  task automatic next_cycle();
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clock);
    checks++;
    if ({mem_req_valid, instr_req_ready, data_req_ready, instr_rsp_valid, data_rsp_valid, rsp_err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b required 000000",
               {mem_req_valid, instr_req_ready, data_req_ready, instr_rsp_valid, data_rsp_valid, rsp_err});
    end
    next_cycle();
  endtask

  task automatic test_single_fetch();
    do_reset();
    instr_req_valid = 1; instr_req_addr = 32'h100; mem_req_ready = 1;
    @(negedge clock);
    checks++;
    if ({mem_req_valid, mem_req_wr, mem_req_size, instr_req_ready, data_req_ready} !== 6'b101010 ||
        mem_req_addr !== 32'h100 || mem_req_data !== 32'h0) begin
      errors++;
      $display("FAIL fetch_req: got v/wr/sz/ir/dr=%b addr=%h data=%h required 101010 addr=100 data=0",
               {mem_req_valid, mem_req_wr, mem_req_size, instr_req_ready, data_req_ready},
               mem_req_addr, mem_req_data);
    end
    next_cycle();
    instr_req_valid = 0; mem_rsp_valid = 1; mem_rsp_data = 32'h13;
    @(negedge clock);
    checks++;
    if (instr_rsp_valid !== 1 || data_rsp_valid !== 0 || instr_rsp_data !== 32'h13) begin
      errors++;
      $display("FAIL fetch_rsp: got iv=%b dv=%b data=%h required iv=1 dv=0 data=13",
               instr_rsp_valid, data_rsp_valid, instr_rsp_data);
    end
    next_cycle();
    // FIFO should be empty again: a further response must be flagged.
    mem_rsp_data = 32'h99;
    @(negedge clock);
    checks++;
    if (instr_rsp_valid !== 0 || data_rsp_valid !== 0) begin
      errors++;
      $display("FAIL fetch_empty_after: got iv=%b dv=%b required 0 0", instr_rsp_valid, data_rsp_valid);
    end
    next_cycle();
    mem_rsp_valid = 0;
    @(negedge clock);
    checks++;
    if (rsp_err !== 1) begin
      errors++;
      $display("FAIL fetch_err_set: got %b required 1", rsp_err);
    end
    next_cycle();
  endtask

  task automatic test_collision();
    bit exp_data;
    bit last = 1;
    do_reset();
    instr_req_valid = 1; instr_req_addr = 32'h300;
    data_req_valid = 1; data_req_wr = 1; data_req_addr = 32'h200;
    data_req_size = 2; data_req_data = 32'hABCD; mem_req_ready = 1;
    for (int i = 0; i < 4; i++) begin
`ifdef MR1_ARB_RR_EN
      exp_data = !last;
`else
      exp_data = 1;
`endif
      last = exp_data;
      @(negedge clock);
      checks++;
      if (data_req_ready !== exp_data || instr_req_ready !== !exp_data || mem_req_valid !== 1 ||
          mem_req_addr !== (exp_data ? 32'h200 : 32'h300)) begin
        errors++;
        $display("FAIL collision_%0d: got dr=%b ir=%b addr=%h required dr=%b ir=%b", i,
                 data_req_ready, instr_req_ready, mem_req_addr, exp_data, !exp_data);
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_lock();
    do_reset();
    instr_req_valid = 1; instr_req_addr = 32'h400; mem_req_ready = 0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin
        data_req_valid = 1; data_req_wr = 0; data_req_addr = 32'h500; data_req_size = 1;
      end
      @(negedge clock);
      checks++;
      if (mem_req_valid !== 1 || mem_req_addr !== 32'h400 || mem_req_wr !== 0 ||
          mem_req_size !== 2 || instr_req_ready !== 0 || data_req_ready !== 0) begin
        errors++;
        $display("FAIL lock_hold_%0d: got v=%b addr=%h ir=%b dr=%b required v=1 addr=400 ir=0 dr=0",
                 i, mem_req_valid, mem_req_addr, instr_req_ready, data_req_ready);
      end
      next_cycle();
    end
    mem_req_ready = 1;
    @(negedge clock);
    checks++;
    if (instr_req_ready !== 1 || data_req_ready !== 0 || mem_req_addr !== 32'h400) begin
      errors++;
      $display("FAIL lock_release: got ir=%b dr=%b addr=%h required ir=1 dr=0 addr=400",
               instr_req_ready, data_req_ready, mem_req_addr);
    end
    next_cycle();
    instr_req_valid = 0;
    @(negedge clock);
    checks++;
    if (data_req_ready !== 1 || mem_req_addr !== 32'h500 || mem_req_size !== 1) begin
      errors++;
      $display("FAIL lock_next: got dr=%b addr=%h size=%0d required dr=1 addr=500 size=1",
               data_req_ready, mem_req_addr, mem_req_size);
    end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_ordering();
    logic [31:0] rdata [3];
    bit          to_data [3];
    rdata = '{32'hA, 32'hB, 32'hC};
    to_data = '{0, 1, 0};
    do_reset();
    mem_req_ready = 1;
    instr_req_valid = 1; instr_req_addr = 32'h1000;
    next_cycle();
    instr_req_valid = 0;
    data_req_valid = 1; data_req_wr = 0; data_req_addr = 32'h2000; data_req_size = 2;
    next_cycle();
    data_req_valid = 0;
    instr_req_valid = 1; instr_req_addr = 32'h1004;
    next_cycle();
    instr_req_valid = 0;
    for (int i = 0; i < 3; i++) begin
      mem_rsp_valid = 1; mem_rsp_data = rdata[i];
      @(negedge clock);
      checks++;
      if (instr_rsp_valid !== !to_data[i] || data_rsp_valid !== to_data[i] ||
          (to_data[i] ? data_rsp_data : instr_rsp_data) !== rdata[i]) begin
        errors++;
        $display("FAIL order_%0d: got iv=%b dv=%b idata=%h ddata=%h required data=%h to_data=%b",
                 i, instr_rsp_valid, data_rsp_valid, instr_rsp_data, data_rsp_data, rdata[i], to_data[i]);
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_full();
    do_reset();
    mem_req_ready = 1;
    for (int i = 0; i < OM; i++) begin
      instr_req_valid = 1; instr_req_addr = 32'h100 + 32'(i * 4);
      @(negedge clock);
      checks++;
      if (instr_req_ready !== 1) begin
        errors++;
        $display("FAIL full_fill_%0d: got ready=%b required 1", i, instr_req_ready);
      end
      next_cycle();
    end
    data_req_valid = 1; data_req_wr = 0; data_req_addr = 32'h700;
    @(negedge clock);
    checks++;
    if (instr_req_ready !== 0 || data_req_ready !== 0 || mem_req_valid !== 0) begin
      errors++;
      $display("FAIL full_block: got ir=%b dr=%b v=%b required 0 0 0",
               instr_req_ready, data_req_ready, mem_req_valid);
    end
    next_cycle();
    data_req_wr = 1; data_req_data = 32'h5A5A;
    @(negedge clock);
    checks++;
    if (data_req_ready !== 1 || mem_req_wr !== 1 || instr_req_ready !== 0) begin
      errors++;
      $display("FAIL full_store: got dr=%b wr=%b ir=%b required 1 1 0",
               data_req_ready, mem_req_wr, instr_req_ready);
    end
    next_cycle();
    data_req_valid = 0; mem_rsp_valid = 1; mem_rsp_data = 32'h55;
    @(negedge clock);
    checks++;
    if (instr_req_ready !== 0 || instr_rsp_valid !== 1) begin
      errors++;
      $display("FAIL full_pop_same: got ir=%b rsp=%b required ir=0 rsp=1", instr_req_ready, instr_rsp_valid);
    end
    next_cycle();
    mem_rsp_valid = 0;
    @(negedge clock);
    checks++;
    if (instr_req_ready !== 1) begin
      errors++;
      $display("FAIL full_pop_next: got ir=%b required 1", instr_req_ready);
    end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_spurious();
    do_reset();
    mem_rsp_valid = 1; mem_rsp_data = 32'hDEAD;
    @(negedge clock);
    checks++;
    if (instr_rsp_valid !== 0 || data_rsp_valid !== 0 || rsp_err !== 0) begin
      errors++;
      $display("FAIL spurious_rsp: got iv=%b dv=%b err=%b required 0 0 0",
               instr_rsp_valid, data_rsp_valid, rsp_err);
    end
    next_cycle();
    mem_rsp_valid = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks++;
      if (rsp_err !== 1) begin
        errors++;
        $display("FAIL spurious_sticky_%0d: got %b required 1", i, rsp_err);
      end
      next_cycle();
    end
    do_reset();
    @(negedge clock);
    checks++;
    if (rsp_err !== 0) begin
      errors++;
      $display("FAIL spurious_clear: got %b required 0", rsp_err);
    end
    next_cycle();
  endtask

  task automatic test_random();
    bit q[$];
    bit m_lock = 0, m_lock_src = 0, m_last = 1;
    bit ip = 0, dp = 0, full, ie, de, g, ev, head;
    logic [31:0] exp_addr, exp_data;
    logic [1:0]  exp_size;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!ip && ($urandom % 3 == 0)) begin
        ip = 1; instr_req_addr = $urandom;
      end
      if (!dp && ($urandom % 3 == 0)) begin
        dp = 1; data_req_wr = $urandom % 2; data_req_addr = $urandom;
        data_req_size = 2'($urandom % 3); data_req_data = $urandom;
      end
      instr_req_valid = ip; data_req_valid = dp;
      mem_req_ready = ($urandom % 4) != 0;
      mem_rsp_valid = (q.size() > 0) && ($urandom % 2 == 1);
      mem_rsp_data = $urandom;

      full = (q.size() == OM);
      ie = ip && !full;
      de = dp && (data_req_wr || !full);
      if (m_lock) g = m_lock_src;
`ifdef MR1_ARB_RR_EN
      else if (ie && de) g = !m_last;
`endif
      else g = de ? 1'b1 : (ie ? 1'b0 : 1'b1);
      ev = g ? de : ie;
      exp_addr = g ? data_req_addr : instr_req_addr;
      exp_size = g ? data_req_size : 2'd2;
      exp_data = g ? data_req_data : 32'd0;
      head = (q.size() > 0) ? q[0] : 1'b0;

      @(negedge clock);
      checks++;
      if (mem_req_valid !== ev || instr_req_ready !== (ev && !g && mem_req_ready) ||
          data_req_ready !== (ev && g && mem_req_ready)) begin
        errors++;
        $display("FAIL rand_hs_%0d: got v=%b ir=%b dr=%b required v=%b grant=%b mrdy=%b",
                 cyc, mem_req_valid, instr_req_ready, data_req_ready, ev, g, mem_req_ready);
      end
      if (ev) begin
        checks++;
        if (mem_req_addr !== exp_addr || mem_req_size !== exp_size || mem_req_data !== exp_data ||
            mem_req_wr !== (g && data_req_wr)) begin
          errors++;
          $display("FAIL rand_payload_%0d: got addr=%h size=%0d data=%h wr=%b required addr=%h size=%0d data=%h",
                   cyc, mem_req_addr, mem_req_size, mem_req_data, mem_req_wr, exp_addr, exp_size, exp_data);
        end
      end
      checks++;
      if (instr_rsp_valid !== (mem_rsp_valid && !head) || data_rsp_valid !== (mem_rsp_valid && head) ||
          instr_rsp_data !== mem_rsp_data || data_rsp_data !== mem_rsp_data || rsp_err !== 0) begin
        errors++;
        $display("FAIL rand_rsp_%0d: got iv=%b dv=%b err=%b required iv=%b dv=%b err=0",
                 cyc, instr_rsp_valid, data_rsp_valid, rsp_err, mem_rsp_valid && !head, mem_rsp_valid && head);
      end

      if (mem_rsp_valid) void'(q.pop_front());
      if (ev && mem_req_ready) begin
        if (!g || !data_req_wr) q.push_back(g);
        m_last = g;
        m_lock = 0;
        if (g) dp = 0; else ip = 0;
      end else begin
        m_lock = ev;
        m_lock_src = g;
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    test_reset();
    test_single_fetch();
    test_collision();
    test_lock();
    test_ordering();
    test_full();
    test_spurious();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
